// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: per-stage enable/flush, PC write enable, halt
// tracking and a saturating stall-cycle counter.
//
// state | meaning
// RUN   | normal operation
// DWAIT | data-memory access in MEM stage outstanding, pipeline frozen
// HALT  | halt retired; pipeline frozen until reset
module hazard_control_unit #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             mem_branch_taken,
  input  logic             id_jump,
  input  logic             idex_dREN,
  input  logic [4:0]       idex_rt,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, DWAIT, HALT} state_t;

  state_t state, state_next;
  logic   mem_busy;
  logic   load_use;

  assign mem_busy = (mem_dREN | mem_dWEN) & ~dhit;
  assign load_use = idex_dREN & (idex_rt != 5'd0) &
                    ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));

  always_comb begin
    state_next  = state;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    // Outputs are combinational, so gate them while reset is held.
    if (!nRST) begin
      state_next = RUN;
    end else if (state == HALT) begin
      state_next = HALT;
    end else if (wb_halt) begin
      state_next = HALT;
    end else if (mem_busy) begin
      state_next = DWAIT;
    end else begin
      state_next = RUN;
      if (mem_branch_taken) begin
        pc_en       = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        memwb_en    = 1'b1;
      end else if (load_use) begin
        idex_flush = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
      end else if (id_jump) begin
        pc_en      = ihit;
        ifid_flush = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
      end else if (!ihit) begin
        ifid_flush = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
      end else begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        idex_en  = 1'b1;
        exmem_en = 1'b1;
        memwb_en = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
    end else if (!pc_en && (state != HALT) && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign halt = (state == HALT);

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: a 16-bit and a 2-bit counter
// instance share stimulus; expected controls are queued per driven cycle.
module tb_hazard_control_unit;

  logic CLK = 1'b0;
  logic nRST, ihit, dhit, mem_dREN, mem_dWEN, mem_branch_taken, id_jump;
  logic idex_dREN, wb_halt;
  logic [4:0] idex_rt, ifid_rs, ifid_rt;

  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush, halt;
  logic [15:0] stall_cnt;
  logic pc_en2, ifid_en2, idex_en2, exmem_en2, memwb_en2;
  logic ifid_flush2, idex_flush2, exmem_flush2, memwb_flush2, halt2;
  logic [1:0] stall_cnt2;

  always #5 CLK = ~CLK;

  hazard_control_unit #(.CNT_W(16)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_dREN(mem_dREN),
    .mem_dWEN(mem_dWEN), .mem_branch_taken(mem_branch_taken), .id_jump(id_jump),
    .idex_dREN(idex_dREN), .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .wb_halt(wb_halt), .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
    .halt(halt), .stall_cnt(stall_cnt));

  hazard_control_unit #(.CNT_W(2)) dut2 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_dREN(mem_dREN),
    .mem_dWEN(mem_dWEN), .mem_branch_taken(mem_branch_taken), .id_jump(id_jump),
    .idex_dREN(idex_dREN), .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .wb_halt(wb_halt), .pc_en(pc_en2), .ifid_en(ifid_en2), .idex_en(idex_en2),
    .exmem_en(exmem_en2), .memwb_en(memwb_en2), .ifid_flush(ifid_flush2),
    .idex_flush(idex_flush2), .exmem_flush(exmem_flush2), .memwb_flush(memwb_flush2),
    .halt(halt2), .stall_cnt(stall_cnt2));

  wire [9:0] outv  = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                      ifid_flush, idex_flush, exmem_flush, memwb_flush, halt};
  wire [9:0] outv2 = {pc_en2, ifid_en2, idex_en2, exmem_en2, memwb_en2,
                      ifid_flush2, idex_flush2, exmem_flush2, memwb_flush2, halt2};

  // stimulus bits: {wb_halt, ihit, dhit, mem_dREN, mem_dWEN, branch, jump, idex_dREN}
  localparam logic [7:0] S_HALT = 8'h80, S_IH = 8'h40, S_DHIT = 8'h20, S_DREN = 8'h10;
  localparam logic [7:0] S_DWEN = 8'h08, S_BR = 8'h04, S_JMP = 8'h02, S_LD = 8'h01;
  localparam logic [7:0] S_NONE = 8'h00;

  // controls: {pc, ifid, idex, exmem, memwb enables, ifid, idex, exmem, memwb flushes}
  localparam logic [8:0] E_ALL  = 9'b11111_0000;
  localparam logic [8:0] E_FRZ  = 9'b00000_0000;
  localparam logic [8:0] E_BRN  = 9'b10001_1110;
  localparam logic [8:0] E_LU   = 9'b00011_0100;
  localparam logic [8:0] E_JHIT = 9'b10111_1000;
  localparam logic [8:0] E_NOF  = 9'b00111_1000;

  typedef struct packed {
    logic       rst;
    logic [7:0] ctl;
    logic [4:0] irt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [8:0] exp;
  } stim_t;

  typedef struct packed {
    logic [9:0]  outv;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  logic        m_halt = 1'b0;
  logic [15:0] m_cnt  = '0;
  logic [1:0]  m_cnt2 = '0;
  logic        last_pc_en, last_wb, last_rst;

  task automatic drive(input stim_t s);
    exp_t e;
    nRST             = s.rst;
    wb_halt          = s.ctl[7];
    ihit             = s.ctl[6];
    dhit             = s.ctl[5];
    mem_dREN         = s.ctl[4];
    mem_dWEN         = s.ctl[3];
    mem_branch_taken = s.ctl[2];
    id_jump          = s.ctl[1];
    idex_dREN        = s.ctl[0];
    idex_rt          = s.irt;
    ifid_rs          = s.rs;
    ifid_rt          = s.rt;
    e.outv = {s.exp, s.rst ? m_halt : 1'b0};
    e.cnt  = s.rst ? m_cnt : 16'd0;
    e.cnt2 = s.rst ? m_cnt2 : 2'd0;
    sb.push_back(e);
    last_pc_en = s.exp[8];
    last_wb    = s.ctl[7];
    last_rst   = s.rst;
  endtask

  task automatic advance();
    @(posedge CLK);
    if (!last_rst) begin
      m_halt = 1'b0;
      m_cnt  = '0;
      m_cnt2 = '0;
    end else begin
      if (!m_halt && !last_pc_en) begin
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (m_cnt2 != 2'd3) m_cnt2 = m_cnt2 + 2'd1;
      end
      if (last_wb) m_halt = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    stim_t s[4];
    exp_t e;
    s = '{'{1'b0, S_IH, 5'd0, 5'd0, 5'd0, E_FRZ},
          '{1'b0, S_IH, 5'd0, 5'd0, 5'd0, E_FRZ},
          '{1'b1, S_IH, 5'd0, 5'd0, 5'd0, E_ALL},
          '{1'b1, S_IH, 5'd0, 5'd0, 5'd0, E_ALL}};
    foreach (s[i]) begin
      drive(s[i]);
      @(negedge CLK);
      e = sb.pop_front();
      n_tests += 3;
      if (outv !== e.outv) begin n_fail++; $display("FAIL reset_ctl[%0d] got %b want %b", i, outv, e.outv); end
      if (outv2 !== e.outv) begin n_fail++; $display("FAIL reset_ctl2[%0d] got %b want %b", i, outv2, e.outv); end
      if (stall_cnt !== e.cnt || stall_cnt2 !== e.cnt2) begin
        n_fail++; $display("FAIL reset_cnt[%0d] got %0d/%0d want %0d/%0d", i, stall_cnt, stall_cnt2, e.cnt, e.cnt2);
      end
      advance();
    end
  endtask

  task automatic test_load_use();
    stim_t s[5];
    exp_t e;
    s = '{'{1'b1, S_IH | S_LD, 5'd5, 5'd5, 5'd0, E_LU},
          '{1'b1, S_IH,        5'd0, 5'd5, 5'd0, E_ALL},
          '{1'b1, S_IH | S_LD, 5'd0, 5'd0, 5'd0, E_ALL},
          '{1'b1, S_IH | S_LD, 5'd7, 5'd3, 5'd7, E_LU},
          '{1'b1, S_IH | S_LD, 5'd7, 5'd3, 5'd4, E_ALL}};
    foreach (s[i]) begin
      drive(s[i]);
      @(negedge CLK);
      e = sb.pop_front();
      n_tests += 2;
      if (outv !== e.outv) begin n_fail++; $display("FAIL lu_ctl[%0d] got %b want %b", i, outv, e.outv); end
      if (stall_cnt !== e.cnt) begin n_fail++; $display("FAIL lu_cnt[%0d] got %0d want %0d", i, stall_cnt, e.cnt); end
      advance();
    end
  endtask

  task automatic test_dwait();
    stim_t s[10];
    exp_t e;
    s = '{'{1'b1, S_IH | S_DREN,                 5'd0, 5'd0, 5'd0, E_FRZ},
          '{1'b1, S_IH | S_DREN,                 5'd0, 5'd0, 5'd0, E_FRZ},
          '{1'b1, S_IH | S_DREN,                 5'd0, 5'd0, 5'd0, E_FRZ},
          '{1'b1, S_IH | S_DREN | S_DHIT,        5'd0, 5'd0, 5'd0, E_ALL},
          '{1'b1, S_IH,                          5'd0, 5'd0, 5'd0, E_ALL},
          '{1'b1, S_IH | S_DWEN | S_DHIT,        5'd0, 5'd0, 5'd0, E_ALL},
          '{1'b1, S_IH | S_DWEN,                 5'd0, 5'd0, 5'd0, E_FRZ},
          '{1'b1, S_IH | S_DWEN | S_DHIT | S_BR, 5'd0, 5'd0, 5'd0, E_BRN},
          '{1'b1, S_IH | S_DREN | S_BR,          5'd0, 5'd0, 5'd0, E_FRZ},
          '{1'b1, S_IH | S_DREN | S_DHIT,        5'd0, 5'd0, 5'd0, E_ALL}};
    foreach (s[i]) begin
      drive(s[i]);
      @(negedge CLK);
      e = sb.pop_front();
      n_tests += 2;
      if (outv !== e.outv) begin n_fail++; $display("FAIL dwait_ctl[%0d] got %b want %b", i, outv, e.outv); end
      if (stall_cnt !== e.cnt) begin n_fail++; $display("FAIL dwait_cnt[%0d] got %0d want %0d", i, stall_cnt, e.cnt); end
      advance();
    end
  endtask

  task automatic test_branch_vs_load_use();
    stim_t s[3];
    exp_t e;
    s = '{'{1'b1, S_IH | S_BR | S_LD,  5'd5, 5'd5, 5'd0, E_BRN},
          '{1'b1, S_BR | S_LD | S_JMP, 5'd6, 5'd0, 5'd6, E_BRN},
          '{1'b1, S_IH,                5'd0, 5'd0, 5'd0, E_ALL}};
    foreach (s[i]) begin
      drive(s[i]);
      @(negedge CLK);
      e = sb.pop_front();
      n_tests += 2;
      if (outv !== e.outv) begin n_fail++; $display("FAIL brlu_ctl[%0d] got %b want %b", i, outv, e.outv); end
      if (stall_cnt !== e.cnt) begin n_fail++; $display("FAIL brlu_cnt[%0d] got %0d want %0d", i, stall_cnt, e.cnt); end
      advance();
    end
  endtask

  task automatic test_jump();
    stim_t s[5];
    exp_t e;
    s = '{'{1'b1, S_JMP,               5'd0, 5'd0, 5'd0, E_NOF},
          '{1'b1, S_IH | S_JMP,        5'd0, 5'd0, 5'd0, E_JHIT},
          '{1'b1, S_IH | S_JMP | S_LD, 5'd9, 5'd9, 5'd0, E_LU},
          '{1'b1, S_NONE,              5'd0, 5'd0, 5'd0, E_NOF},
          '{1'b1, S_IH,                5'd0, 5'd0, 5'd0, E_ALL}};
    foreach (s[i]) begin
      drive(s[i]);
      @(negedge CLK);
      e = sb.pop_front();
      n_tests += 2;
      if (outv !== e.outv) begin n_fail++; $display("FAIL jump_ctl[%0d] got %b want %b", i, outv, e.outv); end
      if (stall_cnt !== e.cnt) begin n_fail++; $display("FAIL jump_cnt[%0d] got %0d want %0d", i, stall_cnt, e.cnt); end
      advance();
    end
  endtask

  task automatic test_saturation();
    stim_t s[7];
    exp_t e;
    s = '{'{1'b0, S_NONE, 5'd0, 5'd0, 5'd0, E_FRZ},
          '{1'b1, S_NONE, 5'd0, 5'd0, 5'd0, E_NOF},
          '{1'b1, S_NONE, 5'd0, 5'd0, 5'd0, E_NOF},
          '{1'b1, S_NONE, 5'd0, 5'd0, 5'd0, E_NOF},
          '{1'b1, S_NONE, 5'd0, 5'd0, 5'd0, E_NOF},
          '{1'b1, S_NONE, 5'd0, 5'd0, 5'd0, E_NOF},
          '{1'b1, S_IH,   5'd0, 5'd0, 5'd0, E_ALL}};
    foreach (s[i]) begin
      drive(s[i]);
      @(negedge CLK);
      e = sb.pop_front();
      n_tests += 3;
      if (outv2 !== e.outv) begin n_fail++; $display("FAIL sat_ctl[%0d] got %b want %b", i, outv2, e.outv); end
      if (stall_cnt2 !== e.cnt2) begin n_fail++; $display("FAIL sat_cnt2[%0d] got %0d want %0d", i, stall_cnt2, e.cnt2); end
      if (stall_cnt !== e.cnt) begin n_fail++; $display("FAIL sat_cnt16[%0d] got %0d want %0d", i, stall_cnt, e.cnt); end
      advance();
    end
  endtask

  task automatic test_halt();
    stim_t s[7];
    exp_t e;
    s = '{'{1'b1, S_HALT | S_IH | S_DREN, 5'd0, 5'd0, 5'd0, E_FRZ},
          '{1'b1, S_IH | S_BR,            5'd0, 5'd0, 5'd0, E_FRZ},
          '{1'b1, S_IH | S_JMP,           5'd0, 5'd0, 5'd0, E_FRZ},
          '{1'b1, S_NONE,                 5'd0, 5'd0, 5'd0, E_FRZ},
          '{1'b0, S_IH,                   5'd0, 5'd0, 5'd0, E_FRZ},
          '{1'b1, S_IH,                   5'd0, 5'd0, 5'd0, E_ALL},
          '{1'b1, S_IH,                   5'd0, 5'd0, 5'd0, E_ALL}};
    foreach (s[i]) begin
      drive(s[i]);
      @(negedge CLK);
      e = sb.pop_front();
      n_tests += 3;
      if (outv !== e.outv) begin n_fail++; $display("FAIL halt_ctl[%0d] got %b want %b", i, outv, e.outv); end
      if (outv2 !== e.outv) begin n_fail++; $display("FAIL halt_ctl2[%0d] got %b want %b", i, outv2, e.outv); end
      if (stall_cnt !== e.cnt || stall_cnt2 !== e.cnt2) begin
        n_fail++; $display("FAIL halt_cnt[%0d] got %0d/%0d want %0d/%0d", i, stall_cnt, stall_cnt2, e.cnt, e.cnt2);
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_dwait();
    test_branch_vs_load_use();
    test_jump();
    test_saturation();
    test_halt();
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain got %0d entries want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Generates the per-stage `enable` and `flush` controls consumed by the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC write enable. It is the driving end of the pipeline-register control interface. It resolves memory-wait stalls, load-use stalls, branch/jump flushes and halt into one priority-ordered decision per cycle. A small FSM tracks outstanding data-memory waits and the halted condition, and a saturating counter records stalled cycles.

## Interface
- CNT_W, 16, width of the stall-cycle counter.
- CLK  in  1  system clock; all state updates on rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- ihit  in  1  instruction fetch completes this cycle.
- dhit  in  1  data access in MEM stage completes this cycle.
- mem_dREN  in  1  EX/MEM register holds a load.
- mem_dWEN  in  1  EX/MEM register holds a store.
- mem_branch_taken  in  1  branch resolved taken in MEM stage.
- id_jump  in  1  J/JAL/JR decoded in ID stage.
- idex_dREN  in  1  ID/EX register holds a load.
- idex_rt  in  5  destination register of the load in ID/EX.
- ifid_rs  in  5  rs field of the instruction in IF/ID.
- ifid_rt  in  5  rt field of the instruction in IF/ID.
- wb_halt  in  1  halt instruction present in MEM/WB register.
- pc_en  out  1  PC may load its next value.
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register enables.
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  register flushes. Flush overrides enable at the register.
- halt  out  1  processor halted (registered).
- stall_cnt  out  CNT_W  saturating count of cycles with pc_en=0 while not halted.

## Operation
- FSM states: RUN, DWAIT, HALT. Reset state is RUN.
- "mem_busy" = (mem_dREN | mem_dWEN) & ~dhit.
- "load_use" = idex_dREN & (idex_rt != 0) & (idex_rt == ifid_rs | idex_rt == ifid_rt).
- Decision priority per cycle. Unlisted outputs are 0. "All en" means pc_en and the four register enables.
  1. State HALT: all en=0, all flush=0. The FSM stays in HALT until reset.
  2. wb_halt: all en=0. Next state is HALT.
  3. mem_busy, in RUN or DWAIT: all en=0 (full freeze). Next state is DWAIT.
  4. mem_branch_taken: pc_en=1, ifid_flush=idex_flush=exmem_flush=1, memwb_en=1.
  5. load_use: pc_en=0, ifid_en=0, idex_flush=1, exmem_en=memwb_en=1.
  6. id_jump: pc_en=ihit, ifid_flush=1, idex_en=exmem_en=memwb_en=1.
  7. ~ihit: pc_en=0, ifid_flush=1 (bubble), idex_en=exmem_en=memwb_en=1.
  8. Otherwise: all en=1.
- In DWAIT, once dhit=1, rules 4–8 apply in that same cycle and the next state is RUN. A completed access therefore advances exactly once.
- In RUN, an access with dhit=1 in the same cycle never enters DWAIT.
- halt = (state == HALT). It rises one cycle after wb_halt is sampled.
- stall_cnt increments by 1 on each rising edge where pc_en=0 and state != HALT. It saturates at 2^CNT_W−1 and never wraps.
- r0 never causes a load-use stall.

## Timing
- All enable and flush outputs are combinational from the current state and current inputs, so the registers sample them on the same edge. There is no added latency.
- State, halt and stall_cnt are registered.
- While nRST=0: all en=0, all flush=0, halt=0, stall_cnt=0, state=RUN.
- When nRST asserts mid-operation, DWAIT or HALT is abandoned immediately.
- Simultaneous events resolve strictly by the priority list:
  - wb_halt beats mem_busy.
  - mem_busy beats branch.
  - Branch beats load_use: the flushed instruction needs no stall.
  - load_use beats jump.
  - Jump with ~ihit gives pc_en=0 and ifid_flush=1.
- A load-use stall lasts exactly one cycle. In the next cycle ID/EX holds a bubble, so load_use is false.

## Test plan
- Reset check: hold nRST=0 with ihit=1 → all en/flush=0, halt=0, stall_cnt=0. Release with ihit=1 and no hazards → all en=1.
- Load-use: idex_dREN=1, idex_rt=5, ifid_rs=5, ihit=1 → pc_en=0, ifid_en=0, idex_flush=1, stall_cnt +1. Repeat with idex_rt=0 → no stall.
- Data wait: mem_dREN=1, dhit=0 for 3 cycles, then dhit=1 → three full-freeze cycles in DWAIT, then one advance cycle (all en=1), state RUN, stall_cnt +3.
- Branch vs load_use: mem_branch_taken=1 together with load_use true → pc_en=1, ifid/idex/exmem_flush=1, no stall.
- Jump without fetch: id_jump=1, ihit=0 → pc_en=0, ifid_flush=1. Same with ihit=1 → pc_en=1.
- Halt and saturation: pulse wb_halt=1 → halt=1 on the next edge, all en=0 thereafter despite ihit and branch inputs, stall_cnt frozen. With CNT_W=2, hold ~ihit for 5 cycles → stall_cnt stops at 3.
